conv832_ctrl: RTL and testbench

Sequencing and arbitration controller for the PHY's 8→32 byte-to-word converter. It accepts byte streams from two requesters with valid/ready handshakes and grants the converter to one requester per word, so bytes from different sources never mix inside a word. It drives the converter's width select (PCLK), enable (ENB), byte input and byte position. It also signals word completion and aborts stalled partial words after a timeout.

---
 rtl/conv832_ctrl.sv | 117 +++++++++++
 tb/tb_conv832_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv832_ctrl.sv
// Arbitration and sequencing controller for the PHY 8->32 byte-to-word converter.
// Two valid/ready byte requesters share the converter one whole word at a time.
module conv832_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_l,
   input  logic [1:0] mode,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req0_ready,
   output logic       req1_ready,
   output logic [1:0] pclk,
   output logic       enb,
   output logic [7:0] in_data,
   output logic [1:0] byte_idx,
   output logic       word_done,
   output logic       owner,
   output logic       flush
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state, stateNext;
   logic [1:0] widthReg;
   logic [1:0] idx;
   logic [1:0] widthSel;
   logic [1:0] lastIdx;
   logic [1:0] curIdx;
   logic       lastServed;
   logic       ownerReg;
   logic       anyValid;
   logic       grant;
   logic       selOwner;
   logic       selValid;
   logic       accept;
   logic       isLast;
   logic       timeoutHit;
   logic [7:0] selData;
   logic [7:0] idleCnt;

   // Select the requester in charge this cycle: round-robin grant when no word
   // is open, otherwise the owner of the open word.
   always_comb begin
      anyValid   = req0_valid | req1_valid;
      grant      = (req0_valid && req1_valid) ? ~lastServed : req1_valid;
      selOwner   = (state == IDLE) ? grant : ownerReg;
      selValid   = selOwner ? req1_valid : req0_valid;
      selData    = selOwner ? req1_data : req0_data;
      accept     = selValid;
      widthSel   = (state == IDLE) ? ((mode == 2'b11) ? 2'b10 : mode) : widthReg;
      case (widthSel)
         2'b00:   lastIdx = 2'd0;
         2'b01:   lastIdx = 2'd1;
         default: lastIdx = 2'd3;
      endcase
      curIdx     = (state == IDLE) ? 2'd0 : idx;
      isLast     = accept && (curIdx == lastIdx);
      timeoutHit = (state == BUSY) && !selValid && (idleCnt == 8'(TIMEOUT - 1));
   end

   assign req0_ready = reset_l && ((state == IDLE) ? (anyValid && !grant) : !ownerReg);
   assign req1_ready = reset_l && ((state == IDLE) ? (anyValid && grant) : ownerReg);
   assign pclk       = widthReg;
   assign owner      = ownerReg;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) state <= IDLE;
      else          state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept && !isLast) stateNext = BUSY;
         BUSY:    if (isLast || timeoutHit) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Converter-facing outputs are registered one cycle behind the handshake;
   // width and owner are captured only on the first byte of a word.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         enb        <= 1'b0;
         in_data    <= 8'h00;
         byte_idx   <= 2'd0;
         word_done  <= 1'b0;
         flush      <= 1'b0;
         widthReg   <= 2'b00;
         ownerReg   <= 1'b0;
         lastServed <= 1'b1;
         idx        <= 2'd0;
         idleCnt    <= 8'd0;
      end else begin
         enb       <= accept;
         word_done <= isLast;
         flush     <= timeoutHit;
         if (accept) begin
            in_data  <= selData;
            byte_idx <= curIdx;
            idx      <= curIdx + 2'd1;
         end
         if (timeoutHit) idx <= 2'd0;
         if (accept && (state == IDLE)) begin
            widthReg <= widthSel;
            ownerReg <= grant;
         end
         if (isLast || timeoutHit) lastServed <= selOwner;
         if ((state == BUSY) && !accept && !timeoutHit) idleCnt <= idleCnt + 8'd1;
         else                                            idleCnt <= 8'd0;
      end
   end

endmodule

// File: tb/tb_conv832_ctrl.sv
// Scoreboard bench for conv832_ctrl: a word-level reference model predicts grants,
// converter bytes and flushes; a monitor compares every converter cycle.
module tb_conv832_ctrl;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset_l;
   logic [1:0] mode;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [1:0] pclk;
   logic       enb;
   logic [7:0] in_data;
   logic [1:0] byte_idx;
   logic       word_done, owner, flush;

   always #5 clk = ~clk;

   conv832_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_l(reset_l), .mode(mode),
      .req0_valid(req0_valid), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .pclk(pclk), .enb(enb), .in_data(in_data), .byte_idx(byte_idx),
      .word_done(word_done), .owner(owner), .flush(flush)
   );

   typedef struct {
      logic [7:0] data;
      logic [1:0] idx;
      logic       done;
      logic       own;
      logic [1:0] pc;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;

   // Reference model: one open word at a time, tracked as owner/width/position.
   bit         mOpen = 0;
   bit         mOwner = 0;
   bit         mLast = 1;
   bit         expFlush = 0;
   bit         acc0, acc1;
   int         mWidth = 1;
   int         mPos = 0;
   int         mStall = 0;
   logic [1:0] mPclk = 2'b00;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, required, $time);
      end
   endtask

   function automatic int bytesOf(input logic [1:0] m);
      return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
   endfunction

   // Drive one cycle of inputs, check READY/FLUSH, then advance the model.
   task automatic applyStimulus(input bit v0, input logic [7:0] d0, input bit v1,
                                input logic [7:0] d1, input logic [1:0] m);
      bit   r0, r1;
      exp_t e;
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      mode = m;
      @(negedge clk);
      if (mOpen) begin
         r0 = !mOwner;
         r1 = mOwner;
      end else begin
         r0 = v0 && (!v1 || mLast);
         r1 = v1 && (!v0 || !mLast);
      end
      checkOutput("req0_ready", req0_ready, r0);
      checkOutput("req1_ready", req1_ready, r1);
      checkOutput("flush", flush, expFlush);
      acc0 = r0 && v0;
      acc1 = r1 && v1;
      expFlush = 0;
      if (acc0 || acc1) begin
         if (!mOpen) begin
            mWidth = bytesOf(m);
            mPclk  = (m == 2'b11) ? 2'b10 : m;
            mOwner = acc1;
            mPos   = 0;
            mOpen  = 1;
         end
         e.data = acc1 ? d1 : d0;
         e.idx  = 2'(mPos);
         e.done = (mPos == mWidth - 1);
         e.own  = mOwner;
         e.pc   = mPclk;
         expQ.push_back(e);
         mPos++;
         mStall = 0;
         if (e.done) begin
            mOpen = 0;
            mLast = mOwner;
         end
      end else if (mOpen) begin
         mStall++;
         if (mStall == TIMEOUT) begin
            mOpen    = 0;
            mLast    = mOwner;
            expFlush = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_pclk"}, pclk, 0);
      checkOutput({tag, "_enb"}, enb, 0);
      checkOutput({tag, "_in_data"}, in_data, 0);
      checkOutput({tag, "_byte_idx"}, byte_idx, 0);
      checkOutput({tag, "_word_done"}, word_done, 0);
      checkOutput({tag, "_owner"}, owner, 0);
      checkOutput({tag, "_flush"}, flush, 0);
      checkOutput({tag, "_req0_ready"}, req0_ready, 0);
      checkOutput({tag, "_req1_ready"}, req1_ready, 0);
   endtask

   task automatic resetMidWord();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      reset_l = 1'b0;
      expQ.delete();
      mOpen = 0; mLast = 1; expFlush = 0; mStall = 0;
      #1;
      checkResetValues("midreset");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_l = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle with an expected byte must show ENB with that byte.
   always begin
      @(posedge clk);
      #3;
      if (reset_l === 1'b1) begin
         if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput("enb", enb, 1);
            checkOutput("in_data", in_data, monE.data);
            checkOutput("byte_idx", byte_idx, monE.idx);
            checkOutput("word_done", word_done, monE.done);
            checkOutput("owner", owner, monE.own);
            checkOutput("pclk", pclk, monE.pc);
         end else begin
            checkOutput("enb_idle", enb, 0);
         end
         if (enb === 1'b1) checkOutput("flush_with_enb", flush, 0);
      end
   end

   initial begin
      logic [7:0] plan1 [4];
      int         n0, n1, seq0, seq1, prob;
      bit         v0, v1;
      plan1 = '{8'h11, 8'h22, 8'h33, 8'h44};
      reset_l = 1'b0;
      mode = 2'b00;
      req0_valid = 1'b1; req0_data = 8'h00;
      req1_valid = 1'b1; req1_data = 8'h00;
      @(negedge clk);
      checkResetValues("reset");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      reset_l = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] 4-byte word from REQ0");
      n0 = 0;
      for (int c = 0; c < 20 && n0 < 4; c++) begin
         applyStimulus(1, plan1[n0], 0, 8'h00, 2'b10);
         if (acc0) n0++;
      end
      repeat (2) applyStimulus(0, 8'h00, 0, 8'h00, 2'b10);

      $display("[TB] 2-byte words, both requesters");
      n0 = 0; n1 = 0;
      for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
         applyStimulus(n0 < 4, 8'(8'hA0 + n0), n1 < 4, 8'(8'hB0 + n1), 2'b01);
         if (acc0) n0++;
         if (acc1) n1++;
      end

      $display("[TB] 1-byte words, both requesters");
      for (int c = 0; c < 8; c++) applyStimulus(1, 8'(8'h50 + c), 1, 8'(8'h60 + c), 2'b00);

      $display("[TB] timeout flush");
      n0 = 0;
      for (int c = 0; c < 10 && n0 < 2; c++) begin
         applyStimulus(1, 8'(8'hC0 + n0), 0, 8'h00, 2'b10);
         if (acc0) n0++;
      end
      n1 = 0;
      for (int c = 0; c < 60 && n1 < 4; c++) begin
         applyStimulus(0, 8'h00, 1, 8'(8'hD0 + n1), 2'b10);
         if (acc1) n1++;
      end

      $display("[TB] mode change inside a word");
      n0 = 0;
      for (int c = 0; c < 20 && n0 < 6; c++) begin
         applyStimulus(1, 8'(8'hE0 + n0), 0, 8'h00, (n0 == 0) ? 2'b10 : 2'b00);
         if (acc0) n0++;
      end

      $display("[TB] reset mid-word");
      n0 = 0;
      for (int c = 0; c < 10 && n0 < 2; c++) begin
         applyStimulus(1, 8'(8'hF0 + n0), 0, 8'h00, 2'b11);
         if (acc0) n0++;
      end
      resetMidWord();
      for (int c = 0; c < 8; c++) applyStimulus(1, 8'(8'h70 + c), 1, 8'(8'h90 + c), 2'b10);

      $display("[TB] randomized traffic");
      seq0 = 0; seq1 = 128;
      for (int c = 0; c < 3000; c++) begin
         case ((c / 300) % 3)
            0:       prob = 85;
            1:       prob = 40;
            default: prob = 4;
         endcase
         v0 = ($urandom_range(0, 99) < prob);
         v1 = ($urandom_range(0, 99) < prob);
         applyStimulus(v0, 8'(seq0), v1, 8'(seq1), 2'($urandom_range(0, 3)));
         if (acc0) seq0++;
         if (acc1) seq1++;
      end

      repeat (20) applyStimulus(0, 8'h00, 0, 8'h00, 2'b00);
      checkOutput("queue_drained", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
